// File: rtl/pipe_ctrl_pkg.sv
// Shared halt-FSM state encoding and hazard-priority encoding for pipe_ctrl.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // HZ_FETCH also covers every "register 0 takes a bubble" case (drain, halt accept).
    typedef enum logic [2:0] {
        HZ_NONE,
        HZ_FETCH,
        HZ_REDIRECT,
        HZ_LOAD_USE,
        HZ_DSTALL,
        HZ_FREEZE
    } hazard_t;

    function automatic hazard_t hz_pick(input logic dstall, input logic load_use,
                                        input logic redirect, input logic fetch_miss);
        if (dstall)          return HZ_DSTALL;
        else if (load_use)   return HZ_LOAD_USE;
        else if (redirect)   return HZ_REDIRECT;
        else if (fetch_miss) return HZ_FETCH;
        else                 return HZ_NONE;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running performance counters for pipe_ctrl; used only with PIPE_CTRL_PERF_EN.
module pipe_perf_cnt (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        run,
    input  logic        stall,
    input  logic        bubble,
    output logic [31:0] cyc_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cyc_cnt    <= '0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (run) begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (stall)  stall_cnt  <= stall_cnt + 32'd1;
            if (bubble) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller with halt-drain FSM.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGES   = 5,
    parameter int MEM_STAGE = 3
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               mem_req,
    input  logic               load_use,
    input  logic               redirect,
    input  logic               halt_req,
    output logic               pc_en,
    output logic               iren,
    output logic [NSTAGES-2:0] stage_en,
    output logic [NSTAGES-2:0] stage_vld,
    output logic               halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]        cyc_cnt,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        bubble_cnt
`endif
);

    localparam int NR = NSTAGES - 1;

    logic [1:0]    state, state_n;
    logic          dstall, halt_acc;
    hazard_t       hz;
    logic [NR-1:0] vld_n, prev_vld;

    assign dstall   = mem_req & ~dhit & stage_vld[MEM_STAGE-1];
    assign halt_acc = (state == ST_RUN) & halt_req & ~dstall & ~load_use;
    assign prev_vld = {stage_vld[NR-2:0], 1'b1};
    assign iren     = (state == ST_RUN) & ~dstall;
    assign halted   = (state == ST_HALTED);

    // An accepted halt stops fetch at once, so it also overrides a same-cycle redirect.
    always_comb begin
        hz    = HZ_FREEZE;
        pc_en = 1'b0;
        case (state)
            ST_RUN: begin
                hz    = halt_acc ? HZ_FETCH : hz_pick(dstall, load_use, redirect, ~ihit);
                pc_en = ~halt_acc & ((hz == HZ_NONE) | (hz == HZ_REDIRECT));
            end
            ST_DRAIN: hz = dstall ? HZ_DSTALL : HZ_FETCH;
            default:  hz = HZ_FREEZE;
        endcase
    end

    // Holding a register reloads its own vld; a bubble sets en with vld cleared.
    always_comb begin
        for (int k = 0; k < NR; k++) begin
            stage_en[k] = 1'b1;
            vld_n[k]    = prev_vld[k];
            case (hz)
                HZ_DSTALL: begin
                    if (k < MEM_STAGE) begin
                        stage_en[k] = 1'b0;
                        vld_n[k]    = stage_vld[k];
                    end else if (k == MEM_STAGE) begin
                        vld_n[k] = 1'b0;
                    end
                end
                HZ_LOAD_USE: begin
                    if (k == 0) begin
                        stage_en[k] = 1'b0;
                        vld_n[k]    = stage_vld[k];
                    end else if (k == 1) begin
                        vld_n[k] = 1'b0;
                    end
                end
                HZ_REDIRECT, HZ_FETCH: if (k == 0) vld_n[k] = 1'b0;
                HZ_FREEZE: begin
                    stage_en[k] = 1'b0;
                    vld_n[k]    = stage_vld[k];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_RUN:   if (halt_acc) state_n = ST_DRAIN;
            ST_DRAIN: if (~|stage_vld) state_n = ST_HALTED;
            default:  state_n = ST_HALTED;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= ST_RUN;
            stage_vld <= '0;
        end else begin
            state     <= state_n;
            stage_vld <= vld_n;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt u_perf (
        .CLK        (CLK),
        .nRST       (nRST),
        .run        (state != ST_HALTED),
        .stall      ((hz == HZ_DSTALL) | (hz == HZ_LOAD_USE)),
        .bubble     (stage_en[NR-1] & ~vld_n[NR-1]),
        .cyc_cnt    (cyc_cnt),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (default NSTAGES=5, MEM_STAGE=3).
module tb_pipe_ctrl;

    logic       CLK = 1'b0;
    logic       nRST, ihit, dhit, mem_req, load_use, redirect, halt_req;
    logic       pc_en, iren, halted;
    logic [3:0] stage_en, stage_vld;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] cyc_cnt, stall_cnt, bubble_cnt;
    logic [31:0] s0, b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    pipe_ctrl dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .ihit      (ihit),
        .dhit      (dhit),
        .mem_req   (mem_req),
        .load_use  (load_use),
        .redirect  (redirect),
        .halt_req  (halt_req),
        .pc_en     (pc_en),
        .iren      (iren),
        .stage_en  (stage_en),
        .stage_vld (stage_vld),
        .halted    (halted)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .cyc_cnt   (cyc_cnt),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; mem_req = 1'b0;
        load_use = 1'b0; redirect = 1'b0; halt_req = 1'b0;
        #12;
        chk("rst_vld", {28'd0, stage_vld}, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_iren", {31'd0, iren}, 32'd1);
        chk("rst_pc_en_noihit", {31'd0, pc_en}, 32'd0);
        ihit = 1'b1;
        #1;
        chk("rst_pc_en_ihit", {31'd0, pc_en}, 32'd1);
        nRST = 1'b1;

        // fill
        chk("fill_pc_en0", {31'd0, pc_en}, 32'd1);
        tick(); chk("fill_vld1", {28'd0, stage_vld}, 32'h1);
        chk("fill_pc_en1", {31'd0, pc_en}, 32'd1);
        tick(); chk("fill_vld2", {28'd0, stage_vld}, 32'h3);
        chk("fill_pc_en2", {31'd0, pc_en}, 32'd1);
        tick(); chk("fill_vld3", {28'd0, stage_vld}, 32'h7);
        chk("fill_pc_en3", {31'd0, pc_en}, 32'd1);
        tick(); chk("fill_vld4", {28'd0, stage_vld}, 32'hF);
        chk("run_en", {28'd0, stage_en}, 32'hF);

        // data stall for 3 cycles
`ifdef PIPE_CTRL_PERF_EN
        s0 = stall_cnt; b0 = bubble_cnt;
`endif
        mem_req = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dst_pc_en", {31'd0, pc_en}, 32'd0);
            chk("dst_iren", {31'd0, iren}, 32'd0);
            chk("dst_en", {28'd0, stage_en}, 32'h8);
            tick();
            chk("dst_vld", {28'd0, stage_vld}, 32'h7);
        end
        dhit = 1'b1;
        #1;
        chk("dst_resume_iren", {31'd0, iren}, 32'd1);
        chk("dst_resume_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        chk("dst_resume_vld", {28'd0, stage_vld}, 32'hF);
        mem_req = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall", stall_cnt - s0, 32'd3);
        chk("perf_bubble", bubble_cnt - b0, 32'd3);
`endif

        // load-use bubble
        load_use = 1'b1;
        #1;
        chk("lu_pc_en", {31'd0, pc_en}, 32'd0);
        chk("lu_en", {28'd0, stage_en}, 32'hE);
        tick();
        chk("lu_vld1", {28'd0, stage_vld}, 32'hD);
        load_use = 1'b0;
        tick(); chk("lu_vld2", {28'd0, stage_vld}, 32'hB);
        tick(); chk("lu_vld3", {28'd0, stage_vld}, 32'h7);
        tick(); chk("lu_vld4", {28'd0, stage_vld}, 32'hF);

        // dstall outranks load_use
        mem_req = 1'b1; dhit = 1'b0; load_use = 1'b1;
        #1;
        chk("prio_dst_en", {28'd0, stage_en}, 32'h8);
        tick();
        chk("prio_dst_vld", {28'd0, stage_vld}, 32'h7);
        mem_req = 1'b0; load_use = 1'b0; dhit = 1'b1;
        tick();
        chk("prio_rec_vld", {28'd0, stage_vld}, 32'hF);

        // redirect outranks fetch miss
        redirect = 1'b1; ihit = 1'b0;
        #1;
        chk("redir_pc_en", {31'd0, pc_en}, 32'd1);
        chk("redir_en", {28'd0, stage_en}, 32'hF);
        tick();
        chk("redir_vld", {28'd0, stage_vld}, 32'hE);
        redirect = 1'b0;
        #1;
        chk("miss_pc_en", {31'd0, pc_en}, 32'd0);
        tick();
        chk("miss_vld", {28'd0, stage_vld}, 32'hC);
        ihit = 1'b1;
        tick(); chk("refill_vld1", {28'd0, stage_vld}, 32'h9);
        tick(); tick(); tick();
        chk("refill_vld4", {28'd0, stage_vld}, 32'hF);

        // halt ignored under load_use
        halt_req = 1'b1; load_use = 1'b1;
        tick();
        chk("halt_ign_iren", {31'd0, iren}, 32'd1);
        chk("halt_ign_vld", {28'd0, stage_vld}, 32'hD);
        halt_req = 1'b0; load_use = 1'b0;
        tick(); tick(); tick();
        chk("halt_ign_refill", {28'd0, stage_vld}, 32'hF);

        // halt + redirect together: halt wins and drains
        halt_req = 1'b1; redirect = 1'b1;
        #1;
        chk("hr_pc_en", {31'd0, pc_en}, 32'd0);
        chk("hr_iren", {31'd0, iren}, 32'd1);
        tick();
        halt_req = 1'b0; redirect = 1'b0;
        chk("drain_iren", {31'd0, iren}, 32'd0);
        chk("drain_pc_en", {31'd0, pc_en}, 32'd0);
        chk("drain_vld1", {28'd0, stage_vld}, 32'hE);
        tick(); chk("drain_vld2", {28'd0, stage_vld}, 32'hC);
        chk("drain_halted2", {31'd0, halted}, 32'd0);
        tick(); chk("drain_vld3", {28'd0, stage_vld}, 32'h8);
        tick(); chk("drain_vld4", {28'd0, stage_vld}, 32'h0);
        chk("drain_halted4", {31'd0, halted}, 32'd0);
        tick(); chk("halted_set", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halted_sticky", {31'd0, halted}, 32'd1);
            chk("halted_en", {28'd0, stage_en}, 32'h0);
            chk("halted_pc_en", {31'd0, pc_en}, 32'd0);
            chk("halted_iren", {31'd0, iren}, 32'd0);
        end

        // reset exits halted
        #2 nRST = 1'b0;
        #1;
        chk("rst_from_halt", {31'd0, halted}, 32'd0);
        chk("rst_from_halt_iren", {31'd0, iren}, 32'd1);
        #1 nRST = 1'b1;

        // memory request with vld[2]=0 is not a stall
        mem_req = 1'b1; dhit = 1'b0;
        #1;
        chk("nostall_iren", {31'd0, iren}, 32'd1);
        chk("nostall_en", {28'd0, stage_en}, 32'hF);
        mem_req = 1'b0;
        tick(); tick(); tick(); tick();
        chk("refill2_vld", {28'd0, stage_vld}, 32'hF);

        // dstall during drain, then reset mid-drain
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        mem_req = 1'b1;
        #1;
        chk("drain_dst_en", {28'd0, stage_en}, 32'h8);
        tick();
        chk("drain_dst_vld", {28'd0, stage_vld}, 32'h6);
        #2 nRST = 1'b0;
        #1;
        chk("mid_rst_vld", {28'd0, stage_vld}, 32'h0);
        chk("mid_rst_halted", {31'd0, halted}, 32'd0);
        mem_req = 1'b0;
        #1 nRST = 1'b1;
        #1;
        chk("mid_rst_iren", {31'd0, iren}, 32'd1);
        chk("mid_rst_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        chk("mid_rst_vld1", {28'd0, stage_vld}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGES, default 5: number of pipeline stages; pipeline registers are indexed 0..NSTAGES-2, and register k feeds stage k+1.
REQ-002 SHALL have parameter MEM_STAGE, default 3: index of the data-memory stage, legal range 2..NSTAGES-2.
REQ-003 SHALL have port CLK, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port nRST, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port ihit, input, 1 bit: instruction fetch complete this cycle.
REQ-006 SHALL have port dhit, input, 1 bit: data access complete this cycle.
REQ-007 SHALL have port mem_req, input, 1 bit: the valid instruction in MEM_STAGE reads or writes memory.
REQ-008 SHALL have port load_use, input, 1 bit: decode-stage load-use hazard.
REQ-009 SHALL have port redirect, input, 1 bit: taken branch or jump resolved in decode.
REQ-010 SHALL have port halt_req, input, 1 bit: halt instruction in decode.
REQ-011 SHALL have port pc_en, output, 1 bit: PC register load enable.
REQ-012 SHALL have port iren, output, 1 bit: instruction memory read request.
REQ-013 SHALL have port stage_en, output, NSTAGES-1 bits: per-register load enable.
REQ-014 SHALL have port stage_vld, output, NSTAGES-1 bits: per-register valid bit, registered.
REQ-015 SHALL have port halted, output, 1 bit: pipeline drained and stopped.

Function
REQ-016 SHALL define dstall = mem_req & ~dhit & stage_vld[MEM_STAGE-1].
REQ-017 SHALL apply hazard priority dstall > load_use > redirect > ~ihit; only the highest active hazard acts.
REQ-018 dstall: pc_en=0; registers 0..MEM_STAGE-1 hold (en=0); register MEM_STAGE loads a bubble (vld<=0); higher registers advance.
REQ-019 load_use (no dstall): pc_en=0; register 0 holds; register 1 loads a bubble; higher registers advance.
REQ-020 redirect (no higher hazard): pc_en=1 (target loaded); register 0 loads a bubble; all others advance.
REQ-021 ~ihit (no higher hazard): pc_en=0; register 0 loads a bubble; all others advance.
REQ-022 No hazard: all registers advance (vld[k] <= vld[k-1], vld[0] <= 1); pc_en=1.
REQ-023 stage_en[k] SHALL be 1 whenever register k loads either data or a bubble; a bubble load SHALL clear only vld, never data.
REQ-024 iren SHALL be 1 only in state RUN and when dstall=0, giving data accesses priority over fetch.
REQ-025 Halt FSM states: RUN, DRAIN, HALTED.
REQ-026 RUN->DRAIN on halt_req when register 0 advances and no dstall or load_use is active; otherwise halt_req SHALL be ignored that cycle.
REQ-027 In DRAIN: pc_en=0, iren=0, register 0 loads bubbles, and other registers follow REQ-018/REQ-022.
REQ-028 DRAIN->HALTED when all stage_vld bits are 0; with no stalls this is NSTAGES-1 cycles after entry.
REQ-029 HALTED: halted=1 sticky, pc_en=0, iren=0, stage_en all 0; exit only by reset.
REQ-030 halt_req and redirect in the same cycle: the halt wins, the pipeline enters DRAIN, and redirect is ignored.

Reset
REQ-031 On nRST low, immediately: state=RUN, stage_vld=0, halted=0, performance counters=0.
REQ-032 Assertion of nRST mid-stall or mid-drain SHALL abandon the operation with no residual state.
REQ-033 First cycle after reset: pc_en=ihit, iren=1.

Configuration
REQ-034 With PIPE_CTRL_PERF_EN defined: additional 32-bit outputs cyc_cnt (increments every cycle not HALTED), stall_cnt (increments on dstall or load_use) and bubble_cnt (increments when register NSTAGES-2 loads vld=0); all wrap at 2^32 and freeze in HALTED.
REQ-035 Without PIPE_CTRL_PERF_EN: these ports and counters SHALL be absent.

Structure
REQ-036 A shared package SHALL hold the halt FSM state enum (RUN, DRAIN, HALTED) and the hazard-priority encoding.
REQ-037 One sub-module, pipe_perf_cnt, SHALL be instantiated only under PIPE_CTRL_PERF_EN; all other logic stays inline.

Verification
REQ-038 Reset, then 4 cycles with ihit=1 and no hazards: stage_vld goes 0000->0001->0011->0111->1111; pc_en=1 every cycle.
REQ-039 Full pipe, mem_req=1, dhit=0 for 3 cycles then 1: stage_vld[2:0] hold, vld[3]=0 for 3 cycles, pc_en=0, iren=0; resume on the 4th cycle.
REQ-040 load_use pulsed for 1 cycle: register 0 holds, vld[1]=0 next cycle, exactly one bubble reaches vld[3] 2 cycles later.
REQ-041 redirect and ~ihit in the same cycle: pc_en=1, vld[0]=0; redirect wins.
REQ-042 halt_req on a full pipe: DRAIN for 4 cycles, then halted=1; iren=0 from the cycle after the request; halted stays 1 for 10 more cycles.
REQ-043 With PIPE_CTRL_PERF_EN, scenario REQ-039: stall_cnt=3 and bubble_cnt=3 after drain-through.
